// File: rtl/thermo_load_sequencer.sv
// Sequencer for the thermometer/shift-register datapath: paces the sweep,
// streams a byte-wide pattern into the shift register and commits it.
module thermo_load_sequencer #(
  parameter int OUT_WIDTH = 256,
  parameter int DWELL_W   = 16,
  localparam int NBYTES   = OUT_WIDTH / 8,
  localparam int CNT_W    = $clog2(NBYTES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_mode,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               start,
  input  logic               abort,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  output logic               s_ready,
  output logic               step_en,
  output logic               shift_en,
  output logic [7:0]         shift_data,
  output logic               sel_shift,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   load_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SWEEP  = 3'd1,
    LOAD   = 3'd2,
    COMMIT = 3'd3,
    HOLD   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
  logic               step_en_q, shift_en_q, sel_shift_q, busy_q, done_q;
  logic [7:0]         shift_data_q;
  logic               accept;

  assign accept = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    dwell_cnt_d = '0;
    load_cnt_d  = load_cnt_q;
    s_ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cfg_mode)  state_d = SWEEP;
        else if (start) state_d = LOAD;
      end
      SWEEP: begin
        // Wrap is tied to the step just issued, so a mid-sweep cfg_dwell
        // change can never produce a step without a wrap or vice versa.
        if (cfg_mode) state_d = IDLE;
        else          dwell_cnt_d = step_en_q ? '0 : dwell_cnt_q + 1'b1;
      end
      LOAD: begin
        s_ready = !abort;
        if (abort) begin
          state_d    = IDLE;
          load_cnt_d = '0;
        end else if (s_valid) begin
          if (load_cnt_q == CNT_W'(NBYTES - 1)) begin
            state_d    = COMMIT;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      COMMIT: state_d = HOLD;
      HOLD: begin
        if (start)         state_d = LOAD;
        else if (!cfg_mode) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dwell_cnt_q  <= '0;
      load_cnt_q   <= '0;
      step_en_q    <= 1'b0;
      shift_en_q   <= 1'b0;
      shift_data_q <= 8'h00;
      sel_shift_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_cnt_q  <= dwell_cnt_d;
      load_cnt_q   <= load_cnt_d;
      step_en_q    <= (state_d == SWEEP) && (dwell_cnt_d == cfg_dwell);
      shift_en_q   <= accept;
      shift_data_q <= accept ? s_data : 8'h00;
      sel_shift_q  <= (state_d == HOLD);
      busy_q       <= (state_d == LOAD) || (state_d == COMMIT);
      done_q       <= (state_q == COMMIT);
    end
  end

  assign step_en    = step_en_q;
  assign shift_en   = shift_en_q;
  assign shift_data = shift_data_q;
  assign sel_shift  = sel_shift_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_cnt   = load_cnt_q;

endmodule
